pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, PC width in bits (minimum 8).
REQ-002 SHALL have parameter STEP, default 4, sequential increment; power of two, 1 to 8.
REQ-003 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'h0000_0080, PC value loaded on exception.
REQ-005 SHALL have port clk, in, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, in, 1: synchronous, active-low (reset==0 at a rising clk edge resets).
REQ-007 SHALL have port stall, in, 1: pipeline hold; PC does not advance.
REQ-008 SHALL have port fetch_ready, in, 1: instruction memory accepts pc this cycle.
REQ-009 SHALL have port redirect_valid, in, 1: branch/jump taken.
REQ-010 SHALL have port redirect_target, in, WIDTH: branch/jump destination.
REQ-011 SHALL have port exc_valid, in, 1: exception request.
REQ-012 SHALL have port pc, out, WIDTH: current fetch address, registered.
REQ-013 SHALL have port pc_valid, out, 1: pc is a valid fetch request.
REQ-014 SHALL have port pc_next_seq, out, WIDTH: pc+STEP (combinational), for link registers.
REQ-015 SHALL have port pending, out, 1: a redirect or exception is buffered.
REQ-016 SHALL have port align_err, out, 1: one-cycle pulse on a misaligned redirect_target.

Function
REQ-017 SHALL implement a three-state FSM: BOOT, RUN, HOLD.
- BOOT is entered on reset.
- BOOT->RUN unconditionally after one cycle.
- RUN->HOLD on a buffered event.
- HOLD->RUN on the advance that consumes the buffer.
REQ-018 In BOOT, pc_valid SHALL be 0; in RUN and HOLD, pc_valid SHALL be 1.
REQ-019 An advance SHALL occur when pc_valid & fetch_ready & !stall.
REQ-020 On an advance, next pc SHALL be selected by this priority:
- exc_valid: EXC_VECTOR.
- redirect_valid: aligned redirect_target.
- pending buffer contents.
- pc+STEP.
REQ-021 If exc_valid or redirect_valid is asserted in a cycle without an advance, the target SHALL be captured into the buffer, and pending SHALL be 1 from the next cycle.
REQ-022 Buffer overwrite rules SHALL be:
- An exception overwrites a buffered redirect.
- A later redirect overwrites a buffered redirect.
- A redirect never overwrites a buffered exception.
REQ-023 If an event is presented in the same cycle that the buffer is consumed, the rule in REQ-020 SHALL apply, and the buffer SHALL be cleared.
REQ-024 Without an advance or a new event, pc and the buffer SHALL hold their values.
REQ-025 Aligned target SHALL be redirect_target with its log2(STEP) LSBs forced to 0.
REQ-026 align_err SHALL pulse in the cycle after redirect_valid is accepted or captured with any of those LSBs set; it does not apply to a redirect masked by exc_valid.
REQ-027 pc+STEP SHALL wrap modulo 2^WIDTH with no error indication.
REQ-028 Events presented during BOOT SHALL be captured into the buffer per REQ-021.

Reset
REQ-029 On reset, outputs SHALL be:
- pc = RESET_VECTOR
- pc_valid = 0
- pending = 0
- align_err = 0
REQ-030 On reset, the buffer SHALL be cleared and the FSM SHALL enter BOOT.
REQ-031 Reset asserted mid-operation, including in HOLD, SHALL discard any buffered event and take priority over all other inputs.

Structure
REQ-032 FSM state encoding and the default vector constants SHALL live in the shared package pc_pkg.
REQ-033 The buffer (target register, exception flag, valid bit, overwrite rules) SHALL be a sub-module pc_redirect_buf; the remainder SHALL be flat in pc_gen.

Verification
REQ-034 The bench SHALL cover these directed scenarios (WIDTH=32, STEP=4 unless noted):
- Reset release, then fetch_ready=1, stall=0 -> pc_valid=0 for 1 cycle; pc sequence 0x0, 0x4, 0x8.
- At pc=0x10, stall=1 and redirect_valid with target 0x200 -> pc holds 0x10, pending=1; stall released -> pc=0x200, pending=0.
- While stalled, redirect 0x200 followed by exc_valid, then redirect 0x300 -> on release pc=0x80.
- At pc=0x20, redirect_valid and exc_valid asserted together on an advance -> pc=0x80, align_err=0.
- Redirect target 0x103 on an advance -> pc=0x100; align_err=1 for exactly one cycle.
- RESET_VECTOR=0xFFFF_FFFC with one advance -> pc=0x0; reset=0 asserted in HOLD -> pc=RESET_VECTOR, pending=0, pc_valid=0.

Source files
------------

// File: rtl/pc_pkg.sv
// ----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program counter generator.
//
// Contents:
//   pc_state_e            - fetch FSM state encoding (BOOT, RUN, HOLD)
//   DEFAULT_RESET_VECTOR  - default address loaded into the PC by reset
//   DEFAULT_EXC_VECTOR    - default address loaded into the PC on an exception
//   MIN_PC_WIDTH          - smallest PC width the generator is meant for
// ----------------------------------------------------------------------------
package pc_pkg;

  // BOOT lasts exactly one cycle after reset and presents no fetch request.
  // RUN is normal sequential fetching, and HOLD means a redirect or
  // exception is parked in the buffer, waiting for the next advance.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

  localparam int MIN_PC_WIDTH = 8;

endpackage : pc_pkg

// File: rtl/pc_redirect_buf.sv
// ----------------------------------------------------------------------------
// pc_redirect_buf
// One-entry buffer that parks a redirect or exception target when it shows
// up in a cycle where the PC cannot advance. The next advance consumes the
// entry, and any advance clears it.
//
// Overwrite policy while the entry is occupied:
//   - an exception replaces a parked redirect (or a parked exception)
//   - a newer redirect replaces a parked redirect
//   - a redirect never replaces a parked exception
//
// Ports:
//   clk_i               - clock, rising edge
//   reset_ni            - synchronous active-low reset, clears the entry
//   advance_i           - the PC advances this cycle (entry is consumed)
//   exc_valid_i         - exception request
//   redirect_valid_i    - branch/jump request
//   redirect_target_i   - branch/jump destination, already aligned
//   valid_o             - entry is occupied
//   is_exc_o            - occupied entry came from an exception
//   target_o            - parked target address
//   capture_o           - some event is written into the entry this cycle
//   redirect_capture_o  - a redirect is written into the entry this cycle
// ----------------------------------------------------------------------------
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             advance_i,
  input  logic             exc_valid_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  output logic             valid_o,
  output logic             is_exc_o,
  output logic [WIDTH-1:0] target_o,
  output logic             capture_o,
  output logic             redirect_capture_o
);

  logic             valid_q, valid_d;
  logic             is_exc_q, is_exc_d;
  logic [WIDTH-1:0] target_q, target_d;

  logic capture_exc;
  logic capture_redirect;

  // Events can only be parked when the PC is not moving. A redirect that
  // arrives together with an exception is masked, and a redirect may not
  // displace a parked exception.
  assign capture_exc      = !advance_i && exc_valid_i;
  assign capture_redirect = !advance_i && !exc_valid_i && redirect_valid_i &&
                            !(valid_q && is_exc_q);

  // Next-state for the entry: an advance always empties it, since the PC
  // either uses the parked target or is overridden by a fresher event.
  always_comb begin
    valid_d  = valid_q;
    is_exc_d = is_exc_q;
    target_d = target_q;
    if (advance_i) begin
      valid_d  = 1'b0;
      is_exc_d = 1'b0;
    end else if (capture_exc) begin
      valid_d  = 1'b1;
      is_exc_d = 1'b1;
      target_d = EXC_VECTOR;
    end else if (capture_redirect) begin
      valid_d  = 1'b1;
      is_exc_d = 1'b0;
      target_d = redirect_target_i;
    end
  end

  // Entry registers; reset discards whatever was parked.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_q  <= 1'b0;
      is_exc_q <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      is_exc_q <= is_exc_d;
      target_q <= target_d;
    end
  end

  assign valid_o            = valid_q;
  assign is_exc_o           = is_exc_q;
  assign target_o           = target_q;
  assign capture_o          = capture_exc || capture_redirect;
  assign redirect_capture_o = capture_redirect;

endmodule : pc_redirect_buf

// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen
// Program counter generator for an in-order fetch stage. Produces a
// registered fetch address, steps it by STEP on every accepted fetch, and
// steers it to exception or branch targets. Targets that arrive while the
// fetch cannot advance are parked in pc_redirect_buf until the next advance.
//
// Parameters:
//   WIDTH         - PC width in bits (8 or more)
//   STEP          - sequential increment, power of two from 1 to 8
//   RESET_VECTOR  - PC value loaded by reset
//   EXC_VECTOR    - PC value loaded on an exception
//
// Ports:
//   clk             - clock, all state changes on the rising edge
//   reset           - synchronous active-low reset
//   stall           - pipeline hold, PC does not advance
//   fetch_ready     - instruction memory accepts pc this cycle
//   redirect_valid  - branch/jump taken
//   redirect_target - branch/jump destination
//   exc_valid       - exception request
//   pc              - current fetch address (registered)
//   pc_valid        - pc is a valid fetch request
//   pc_next_seq     - pc + STEP, for link registers
//   pending         - a redirect or exception is parked
//   align_err       - one-cycle pulse after a misaligned redirect is taken
// ----------------------------------------------------------------------------
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             pending,
  output logic             align_err
);

  // STEP is a power of two, so STEP-1 selects exactly the address bits that
  // must be zero in a legal target. With STEP=1 the mask is empty.
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  pc_state_e        state_q;
  logic             pc_valid_q;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             align_err_q, align_err_d;

  logic             advance;
  logic [WIDTH-1:0] aligned_target;
  logic             target_misaligned;
  logic [WIDTH-1:0] seq_pc;

  logic             buf_valid;
  logic             buf_is_exc;
  logic [WIDTH-1:0] buf_target;
  logic             buf_capture;
  logic             buf_redirect_capture;

  assign advance           = pc_valid_q && fetch_ready && !stall;
  assign aligned_target    = redirect_target & ~ALIGN_MASK;
  assign target_misaligned = |(redirect_target & ALIGN_MASK);
  assign seq_pc            = pc_q + STEP_W;

  pc_redirect_buf #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_buf (
    .clk_i              (clk),
    .reset_ni           (reset),
    .advance_i          (advance),
    .exc_valid_i        (exc_valid),
    .redirect_valid_i   (redirect_valid),
    .redirect_target_i  (aligned_target),
    .valid_o            (buf_valid),
    .is_exc_o           (buf_is_exc),
    .target_o           (buf_target),
    .capture_o          (buf_capture),
    .redirect_capture_o (buf_redirect_capture)
  );

  // Fetch FSM. BOOT gives the memory one quiet cycle after reset, then the
  // machine alternates between RUN and HOLD depending on whether a target
  // is parked. pc_valid is registered alongside the state so it is glitch
  // free. Events seen during BOOT are still parked by the buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          if (buf_capture) begin
            state_q <= HOLD;
          end
          pc_valid_q <= 1'b1;
        end
        HOLD: begin
          if (advance) begin
            state_q <= RUN;
          end
          pc_valid_q <= 1'b1;
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Next PC on an advance: a live exception beats a live redirect, which
  // beats a parked target, which beats the sequential address. A live event
  // on an advance also empties the buffer, so a stale parked target is
  // simply dropped.
  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      if (exc_valid) begin
        pc_d = EXC_VECTOR;
      end else if (redirect_valid) begin
        pc_d = aligned_target;
      end else if (buf_valid) begin
        pc_d = buf_target;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  // A misaligned redirect is flagged only when it actually takes effect:
  // either steering the PC now or landing in the buffer. Redirects masked
  // by an exception, or refused because an exception is already parked,
  // never reach the PC and so are not reported.
  always_comb begin
    align_err_d = 1'b0;
    if (redirect_valid && !exc_valid && target_misaligned &&
        (advance || buf_redirect_capture)) begin
      align_err_d = 1'b1;
    end
  end

  // PC and alignment flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_VECTOR;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      align_err_q <= align_err_d;
    end
  end

  // The parked entry's kind matters only inside the buffer.
  logic unused_buf_is_exc;
  assign unused_buf_is_exc = buf_is_exc;

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign pc_next_seq = seq_pc;
  assign pending     = buf_valid;
  assign align_err   = align_err_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen
// Self-checking bench for pc_gen. Two instances share all inputs: one with
// the default reset vector, one with RESET_VECTOR = 0xFFFF_FFFC so that the
// sequential step wraps past the top of the address space.
// ----------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;

  logic [31:0] pcA, nextSeqA, pcB, nextSeqB;
  logic        validA, pendA, alignA, validB, pendB, alignB;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .pc              (pcA),
    .pc_valid        (validA),
    .pc_next_seq     (nextSeqA),
    .pending         (pendA),
    .align_err       (alignA)
  );

  pc_gen #(
    .RESET_VECTOR (32'hFFFF_FFFC)
  ) dutWrap (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .pc              (pcB),
    .pc_valid        (validB),
    .pc_next_seq     (nextSeqB),
    .pending         (pendB),
    .align_err       (alignB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the parked event is described by a rank (0 none,
  // 1 redirect, 2 exception); a new event is parked when its rank is at
  // least the parked one.
  typedef struct {
    bit          pcValid;
    logic [31:0] pc;
    int          pendRank;
    logic [31:0] pendTarget;
    bit          alignErr;
  } modelT;

  modelT mA, mB;

  function automatic modelT modelStep(input modelT m, input bit resetN,
                                      input bit st, input bit fr, input bit rv,
                                      input logic [31:0] rt, input bit ev,
                                      input logic [31:0] resetVec);
    modelT n;
    bit    adv;
    bit    misaligned;
    int    newRank;
    logic [31:0] target;
    n = m;
    if (!resetN) begin
      n.pcValid    = 1'b0;
      n.pc         = resetVec;
      n.pendRank   = 0;
      n.pendTarget = 32'h0;
      n.alignErr   = 1'b0;
      return n;
    end
    adv        = m.pcValid && fr && !st;
    misaligned = (rt % 4) != 0;
    target     = (rt / 4) * 4;
    n.pcValid  = 1'b1;
    n.alignErr = 1'b0;
    if (adv) begin
      if (ev)                n.pc = 32'h80;
      else if (rv)           n.pc = target;
      else if (m.pendRank>0) n.pc = m.pendTarget;
      else                   n.pc = m.pc + 32'd4;
      n.pendRank = 0;
      if (rv && !ev && misaligned) n.alignErr = 1'b1;
    end else begin
      newRank = ev ? 2 : (rv ? 1 : 0);
      if (newRank > 0 && newRank >= m.pendRank) begin
        n.pendRank   = newRank;
        n.pendTarget = ev ? 32'h80 : target;
        if (!ev && misaligned) n.alignErr = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic compare(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    compare("A.pc", pcA, mA.pc);
    compare("A.pc_valid", 32'(validA), 32'(mA.pcValid));
    compare("A.pending", 32'(pendA), 32'(mA.pendRank != 0));
    compare("A.align_err", 32'(alignA), 32'(mA.alignErr));
    compare("A.pc_next_seq", nextSeqA, mA.pc + 32'd4);
    compare("B.pc", pcB, mB.pc);
    compare("B.pc_valid", 32'(validB), 32'(mB.pcValid));
    compare("B.pending", 32'(pendB), 32'(mB.pendRank != 0));
    compare("B.align_err", 32'(alignB), 32'(mB.alignErr));
    compare("B.pc_next_seq", nextSeqB, mB.pc + 32'd4);
  endtask

  // Drives one cycle of inputs, advances both models, and checks after the edge.
  task automatic applyStimulus(input bit resetN, input bit st, input bit fr,
                               input bit rv, input logic [31:0] rt, input bit ev);
    reset           = resetN;
    stall           = st;
    fetch_ready     = fr;
    redirect_valid  = rv;
    redirect_target = rt;
    exc_valid       = ev;
    mA = modelStep(mA, resetN, st, fr, rv, rt, ev, 32'h0000_0000);
    mB = modelStep(mB, resetN, st, fr, rv, rt, ev, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  typedef struct {
    bit          resetN;
    bit          st;
    bit          fr;
    bit          rv;
    logic [31:0] rt;
    bit          ev;
    logic [31:0] expPc;
    bit          expValid;
    bit          expPend;
    bit          expAlign;
  } vecT;

  vecT vecs[$];

  initial begin
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; exc_valid = 1'b0;
    mA = '{pcValid: 1'b0, pc: 32'h0, pendRank: 0, pendTarget: 32'h0, alignErr: 1'b0};
    mB = mA;

    //               rstN st fr rv  target        ev  expPc         vld pnd aln
    vecs.push_back('{0, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0000, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0000, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0004, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0008, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_000C, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0010, 1, 0, 0});
    vecs.push_back('{1, 1, 1, 1, 32'h0000_0200, 0, 32'h0000_0010, 1, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0200, 1, 0, 0});
    vecs.push_back('{1, 1, 1, 1, 32'h0000_0200, 0, 32'h0000_0200, 1, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0000_0000, 1, 32'h0000_0200, 1, 1, 0});
    vecs.push_back('{1, 1, 1, 1, 32'h0000_0300, 0, 32'h0000_0200, 1, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0080, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 1, 32'h0000_0020, 0, 32'h0000_0020, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 1, 32'h0000_0402, 1, 32'h0000_0080, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 1, 32'h0000_0103, 0, 32'h0000_0100, 1, 0, 1});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0104, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 32'h0000_0000, 0, 32'h0000_0104, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 32'h0000_0205, 0, 32'h0000_0104, 1, 1, 1});
    vecs.push_back('{1, 0, 1, 0, 32'h0000_0000, 0, 32'h0000_0204, 1, 0, 0});
    vecs.push_back('{1, 1, 1, 0, 32'h0000_0000, 1, 32'h0000_0204, 1, 1, 0});
    vecs.push_back('{1, 0, 1, 1, 32'h0000_0500, 0, 32'h0000_0500, 1, 0, 0});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].resetN, vecs[i].st, vecs[i].fr, vecs[i].rv,
                    vecs[i].rt, vecs[i].ev);
      compare($sformatf("tbl%0d.pc", i), pcA, vecs[i].expPc);
      compare($sformatf("tbl%0d.pc_valid", i), 32'(validA), 32'(vecs[i].expValid));
      compare($sformatf("tbl%0d.pending", i), 32'(pendA), 32'(vecs[i].expPend));
      compare($sformatf("tbl%0d.align_err", i), 32'(alignA), 32'(vecs[i].expAlign));
    end

    // Park a redirect (HOLD), then reset with every other input active.
    applyStimulus(1, 1, 1, 1, 32'h0000_0040, 0);
    compare("hold.pending", 32'(pendA), 32'h1);
    applyStimulus(0, 0, 1, 1, 32'h0000_0044, 1);
    compare("rstHold.A.pc", pcA, 32'h0000_0000);
    compare("rstHold.B.pc", pcB, 32'hFFFF_FFFC);
    compare("rstHold.pending", 32'(pendA), 32'h0);
    compare("rstHold.pc_valid", 32'(validA), 32'h0);
    compare("rstHold.align_err", 32'(alignA), 32'h0);

    // A redirect presented during BOOT is parked and used on the first advance.
    applyStimulus(1, 0, 1, 1, 32'h0000_0600, 0);
    compare("boot.A.pc", pcA, 32'h0000_0000);
    compare("boot.pending", 32'(pendA), 32'h1);
    compare("boot.pc_valid", 32'(validA), 32'h1);
    applyStimulus(1, 0, 1, 0, 32'h0, 0);
    compare("bootUse.A.pc", pcA, 32'h0000_0600);
    compare("bootUse.B.pc", pcB, 32'h0000_0600);
    compare("bootUse.pending", 32'(pendA), 32'h0);

    // Sequential wrap from 0xFFFF_FFFC on the second instance.
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 0, 32'h0, 0);
    compare("wrap.B.pc0", pcB, 32'hFFFF_FFFC);
    compare("wrap.B.seq0", nextSeqB, 32'h0000_0000);
    applyStimulus(1, 0, 1, 0, 32'h0, 0);
    compare("wrap.B.pc1", pcB, 32'h0000_0000);
    compare("wrap.B.valid", 32'(validB), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          rN, st, fr, rv, ev;
      logic [31:0] rt;
      rN = ($urandom_range(0, 63) != 0);
      st = ($urandom_range(0, 3) == 0);
      fr = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 3) == 0);
      ev = ($urandom_range(0, 7) == 0);
      rt = $urandom();
      applyStimulus(rN, st, fr, rv, rt, ev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_gen
